// File: rtl/shape_deconv.sv
// shape_deconv: inverts the first-order shaping integrator,
// rebuilding raw samples D from the saturated shaped stream Q.
// Ports: C clock, CLR_N sync active-low reset, sclr history clear,
//   in_valid/in_ready/in_data shaped input, out_valid/out_ready/
//   out_data reconstructed output, out_sat clamp-or-rail flag,
//   clip_cnt saturating count of transferred out_sat samples.
// Optional: define SHAPE_DECONV_CLIPCNT_EN to build the clip counter;
//   otherwise clip_cnt is tied to zero.
module shape_deconv #(
  parameter int N  = 16,
  parameter int B1 = 1
) (
  input  logic                C,
  input  logic                CLR_N,
  input  logic                sclr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] out_data,
  output logic                out_sat,
  output logic [15:0]         clip_cnt
);

  localparam int W = N + 2;

  localparam logic signed [N-1:0] Q_MAX =
    {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] Q_MIN =
    {1'b1, {(N-1){1'b0}}};
  localparam logic signed [W-1:0] R_MAX =
    {3'b000, {(N-1){1'b1}}};
  localparam logic signed [W-1:0] R_MIN =
    {3'b111, {(N-1){1'b0}}};

  // history
  logic signed [N-1:0] q_prev_q, q_prev_d;

  // stage 1
  logic                s1_v_q, s1_v_d;
  logic signed [W-1:0] s1_r_q, s1_r_d;
  logic                s1_rail_q, s1_rail_d;

  // stage 2
  logic                s2_v_q, s2_v_d;
  logic signed [N-1:0] s2_data_q, s2_data_d;
  logic                s2_sat_q, s2_sat_d;

  logic                adv;
  logic                accept;
  logic signed [N-1:0] fb_y;
  logic signed [W-1:0] r_new;
  logic                rail_new;
  logic                clamp_hi;
  logic                clamp_lo;
  logic signed [N-1:0] clamp_data;

  assign adv      = !s2_v_q || out_ready;
  assign accept   = in_valid && adv;
  assign in_ready = adv;

  // Feedback term: floor shift, but never let a non-zero history
  // collapse to zero, mirroring the shaper's deadband nudge.
  always_comb begin
    fb_y = q_prev_q >>> B1;
    if (fb_y == '0 && q_prev_q != '0) begin
      if (q_prev_q[N-1]) begin
        fb_y = {N{1'b1}};
      end else begin
        fb_y = {{(N-1){1'b0}}, 1'b1};
      end
    end
  end

  // Two guard bits hold the worst case of q - q_prev + y.
  always_comb begin
    r_new = {{2{in_data[N-1]}}, in_data}
          - {{2{q_prev_q[N-1]}}, q_prev_q}
          + {{2{fb_y[N-1]}}, fb_y};
    rail_new = (in_data == Q_MAX) || (in_data == Q_MIN);
  end

  always_comb begin
    clamp_hi = s1_r_q > R_MAX;
    clamp_lo = s1_r_q < R_MIN;
    if (clamp_hi) begin
      clamp_data = Q_MAX;
    end else if (clamp_lo) begin
      clamp_data = Q_MIN;
    end else begin
      clamp_data = s1_r_q[N-1:0];
    end
  end

  always_comb begin
    q_prev_d  = q_prev_q;
    s1_v_d    = s1_v_q;
    s1_r_d    = s1_r_q;
    s1_rail_d = s1_rail_q;
    s2_v_d    = s2_v_q;
    s2_data_d = s2_data_q;
    s2_sat_d  = s2_sat_q;
    if (sclr) begin
      // clear wins over a same-cycle input, which is dropped
      q_prev_d = '0;
      s1_v_d   = 1'b0;
      s2_v_d   = 1'b0;
    end else if (adv) begin
      s1_v_d = accept;
      if (accept) begin
        s1_r_d    = r_new;
        s1_rail_d = rail_new;
        q_prev_d  = in_data;
      end
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_data_d = clamp_data;
        s2_sat_d  = clamp_hi || clamp_lo || s1_rail_q;
      end
    end
  end

  always_ff @(posedge C) begin
    if (!CLR_N) begin
      q_prev_q  <= '0;
      s1_v_q    <= 1'b0;
      s1_r_q    <= '0;
      s1_rail_q <= 1'b0;
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
      s2_sat_q  <= 1'b0;
    end else begin
      q_prev_q  <= q_prev_d;
      s1_v_q    <= s1_v_d;
      s1_r_q    <= s1_r_d;
      s1_rail_q <= s1_rail_d;
      s2_v_q    <= s2_v_d;
      s2_data_q <= s2_data_d;
      s2_sat_q  <= s2_sat_d;
    end
  end

  assign out_valid = s2_v_q;
  assign out_data  = s2_data_q;
  assign out_sat   = s2_sat_q;

`ifdef SHAPE_DECONV_CLIPCNT_EN
  logic [15:0] clip_q, clip_d;

  // counts on transfer, independent of sclr
  always_comb begin
    clip_d = clip_q;
    if (s2_v_q && out_ready && s2_sat_q
        && clip_q != 16'hFFFF) begin
      clip_d = clip_q + 16'd1;
    end
  end

  always_ff @(posedge C) begin
    if (!CLR_N) begin
      clip_q <= '0;
    end else begin
      clip_q <= clip_d;
    end
  end

  assign clip_cnt = clip_q;
`else
  assign clip_cnt = '0;
`endif

endmodule

// File: tb/tb_shape_deconv.sv
// tb_shape_deconv: table vectors, hand sequences and a random
// scoreboard run against a plain-arithmetic model of the deconvolver.
module tb_shape_deconv;

  localparam int N  = 16;
  localparam int B1 = 1;
`ifdef SHAPE_DECONV_CLIPCNT_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  logic                C;
  logic                CLR_N;
  logic                sclr;
  logic                in_valid;
  logic                in_ready;
  logic signed [N-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic signed [N-1:0] out_data;
  logic                out_sat;
  logic [15:0]         clip_cnt;

  shape_deconv #(.N(N), .B1(B1)) dut (
    .C         (C),
    .CLR_N     (CLR_N),
    .sclr      (sclr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .clip_cnt  (clip_cnt)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  typedef struct {
    bit clr;
    int q;
    int d;
    bit sat;
  } vec_t;

  typedef struct {
    int d;
    bit sat;
  } exp_t;

  vec_t tv[15];
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   mq = 0;
  int   mclip = 0;
  int   nxfer = 0;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // D[n] = Q[n] - Q[n-1] + floor(Q[n-1]/2^B1), with deadband nudge.
  function automatic void ref_d(input int q, input int qp,
                                output int d, output bit sat);
    int y, r, dv;
    dv = 1 << B1;
    if (qp >= 0) y = qp / dv;
    else y = -((-qp + dv - 1) / dv);
    if (y == 0 && qp > 0) y = 1;
    if (y == 0 && qp < 0) y = -1;
    r = q - qp + y;
    sat = (q == 32767) || (q == -32768)
       || (r > 32767) || (r < -32768);
    if (r > 32767) d = 32767;
    else if (r < -32768) d = -32768;
    else d = r;
  endfunction

  function automatic int rnd_q();
    case ($urandom_range(0, 5))
      0: return 32767;
      1: return -32768;
      2: return int'($urandom_range(0, 20)) - 10;
      default: return int'($signed(16'($urandom)));
    endcase
  endfunction

  // One cycle at the negedge: drive, check handshake and any
  // transfer against the scoreboard, then advance to next negedge.
  task automatic cyc(input bit v, input int d,
                     input bit rdy, input bit s);
    exp_t e;
    int   ed;
    bit   es;
    in_valid  = v;
    in_data   = 16'(d);
    out_ready = rdy;
    sclr      = s;
    #1;
    chk("clip_cnt", int'(clip_cnt), mclip);
    chk("in_ready", int'(in_ready), int'(!out_valid || rdy));
    if (out_valid && rdy) begin
      nxfer++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_out actual=%0d required=none",
                 int'(out_data));
      end else begin
        e = sb.pop_front();
        chk("sb_data", int'(out_data), e.d);
        chk("sb_sat", int'(out_sat), int'(e.sat));
        if (CLIP_EN && e.sat && mclip < 65535) mclip++;
      end
    end
    if (s) begin
      sb.delete();
      mq = 0;
    end else if (v && in_ready) begin
      ref_d(d, mq, ed, es);
      sb.push_back('{ed, es});
      mq = d;
    end
    @(negedge C);
  endtask

  initial begin
    int n0;
    tv[0]  = '{1, 100, 100, 0};
    tv[1]  = '{0, 50, 0, 0};
    tv[2]  = '{0, 25, 0, 0};
    tv[3]  = '{0, 13, 0, 0};
    tv[4]  = '{1, 1, 1, 0};
    tv[5]  = '{0, 0, 0, 0};
    tv[6]  = '{1, -1, -1, 0};
    tv[7]  = '{0, 0, 0, 0};
    tv[8]  = '{1, -32768, -32768, 1};
    tv[9]  = '{0, 32767, 32767, 1};
    tv[10] = '{0, 0, -16384, 0};
    tv[11] = '{0, -32768, -32768, 1};
    tv[12] = '{0, -32767, -16383, 0};
    tv[13] = '{1, 32767, 32767, 1};
    tv[14] = '{0, -32768, -32768, 1};

    CLR_N = 1'b0;
    sclr = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge C);
    CLR_N = 1'b1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_sat", int'(out_sat), 0);
    chk("rst_clip", int'(clip_cnt), 0);
    chk("rst_ready", int'(in_ready), 1);

    // table: one sample at a time, exact 2-cycle latency
    for (int i = 0; i < 15; i++) begin
      if (tv[i].clr) begin
        sclr = 1'b1;
        @(negedge C);
        sclr = 1'b0;
      end
      in_valid = 1'b1;
      in_data = 16'(tv[i].q);
      @(negedge C);
      in_valid = 1'b0;
      chk($sformatf("tbl%0d_lat1", i), int'(out_valid), 0);
      @(negedge C);
      chk($sformatf("tbl%0d_valid", i), int'(out_valid), 1);
      chk($sformatf("tbl%0d_data", i), int'(out_data), tv[i].d);
      chk($sformatf("tbl%0d_sat", i), int'(out_sat),
          int'(tv[i].sat));
      if (CLIP_EN && tv[i].sat) mclip++;
      @(negedge C);
      chk($sformatf("tbl%0d_clip", i), int'(clip_cnt), mclip);
    end

    // back-to-back impulse, exact output cadence
    cyc(0, 0, 1, 1);
    cyc(1, 100, 1, 0);
    cyc(1, 50, 1, 0);
    chk("imp_v0", int'(out_valid), 1);
    chk("imp_d0", int'(out_data), 100);
    cyc(1, 25, 1, 0);
    chk("imp_v1", int'(out_valid), 1);
    cyc(1, 13, 1, 0);
    chk("imp_v2", int'(out_valid), 1);
    cyc(0, 0, 1, 0);
    chk("imp_v3", int'(out_valid), 1);
    cyc(0, 0, 1, 0);
    chk("imp_end", int'(out_valid), 0);
    cyc(0, 0, 1, 0);

    // backpressure
    cyc(0, 0, 1, 1);
    n0 = nxfer;
    cyc(1, 100, 0, 0);
    cyc(1, 50, 0, 0);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      out_ready = 1'b0;
      #1;
      chk("bp_ready", int'(in_ready), 0);
      chk("bp_hold", int'(out_data), 100);
      cyc(1, 25, 0, 0);
    end
    cyc(1, 25, 1, 0);
    cyc(1, 13, 1, 0);
    repeat (4) cyc(0, 0, 1, 0);
    chk("bp_count", nxfer - n0, 4);
    chk("bp_drain", sb.size(), 0);

    // mid-stream clear
    cyc(1, 100, 1, 0);
    cyc(1, 50, 1, 1);
    chk("clr_v1", int'(out_valid), 0);
    cyc(0, 0, 1, 0);
    chk("clr_v2", int'(out_valid), 0);
    cyc(1, 40, 1, 0);
    cyc(0, 0, 1, 0);
    chk("clr_valid", int'(out_valid), 1);
    chk("clr_data", int'(out_data), 40);
    cyc(0, 0, 1, 0);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 3) != 0, rnd_q(),
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 60) == 0);
    end
    repeat (4) cyc(0, 0, 1, 0);
    chk("rnd_drain", sb.size(), 0);

    // reset with a pending output
    cyc(1, 32767, 0, 0);
    cyc(0, 0, 0, 0);
    chk("pre_rst_valid", int'(out_valid), 1);
    CLR_N = 1'b0;
    @(negedge C);
    CLR_N = 1'b1;
    sb.delete();
    mq = 0;
    mclip = 0;
    chk("rst2_valid", int'(out_valid), 0);
    chk("rst2_data", int'(out_data), 0);
    chk("rst2_sat", int'(out_sat), 0);
    chk("rst2_clip", int'(clip_cnt), 0);
    cyc(1, 7, 1, 0);
    cyc(0, 0, 1, 0);
    chk("rst2_v7", int'(out_valid), 1);
    chk("rst2_d7", int'(out_data), 7);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
